// File: rtl/doodle_physics.sv
// doodle_physics: per-frame vertical motion engine for the doodle.
// Integrates a Q.4 velocity with gravity on every frame_tick. A landing
// reported by the collision observer launches a jump. Position is clamped
// at the top of the screen, and the doodle dies at the bottom edge.
// Ports: clk, rst (async, active high), start, frame_tick,
//   doodle_collision, ground_y[9:0] -> doodle_y[9:0],
//   doodle_fall_direction, velocity[11:0] (signed Q.4), bounce, dead,
//   scroll_px[9:0].
// Option: define DOODLE_SCROLL_EN to hold the doodle at SCROLL_LINE while it
//   rises. The excess rise is reported as scroll_px. When the macro is not
//   defined, scroll_px is always 0.
module doodle_physics #(
   parameter int FRAC_BITS   = 4,
   parameter int GRAVITY     = 6,
   parameter int JUMP_VEL    = 224,
   parameter int MAX_FALL    = 256,
   parameter int DOODLE_H    = 80,
   parameter int INIT_Y      = 687,
   parameter int SCREEN_H    = 768,
   parameter int SCROLL_LINE = 420
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               frame_tick,
   input  logic               doodle_collision,
   input  logic [9:0]         ground_y,
   output logic [9:0]         doodle_y,
   output logic               doodle_fall_direction,
   output logic signed [11:0] velocity,
   output logic               bounce,
   output logic               dead,
   output logic [9:0]         scroll_px
);

   typedef enum logic [1:0] {
      S_IDLE, S_RISING, S_FALLING, S_DEAD
   } state_t;

   localparam logic signed [16:0] INIT_P   = 17'(INIT_Y << FRAC_BITS);
   localparam logic signed [16:0] DEAD_P   = 17'((SCREEN_H - 1) << FRAC_BITS);
   localparam logic signed [16:0] SCREEN_P = 17'(SCREEN_H << FRAC_BITS);
   localparam logic signed [12:0] GRAV     = 13'(GRAVITY);
   localparam logic signed [12:0] MAXF     = 13'(MAX_FALL);
   localparam logic signed [11:0] JUMP     = 12'(-JUMP_VEL);
   localparam logic [9:0]         H_SPR    = 10'(DOODLE_H);
`ifdef DOODLE_SCROLL_EN
   localparam logic signed [16:0] SCROLL_I = 17'(SCROLL_LINE);
   localparam logic signed [16:0] SCROLL_P = 17'(SCROLL_LINE << FRAC_BITS);
`endif

   state_t             state_q, state_d;
   logic signed [15:0] pos_q, pos_d;
   logic signed [11:0] vel_q, vel_d;
   logic               coll_q, coll_d;
   logic               bounce_q, bounce_d;
   logic [9:0]         scroll_q, scroll_d;

   logic signed [16:0] pos_n;
   logic signed [12:0] vel_s;
   logic signed [11:0] vel_n;
   logic [9:0]         land_y;
   logic               active;
`ifdef DOODLE_SCROLL_EN
   logic signed [16:0] pos_int;
   logic signed [16:0] scroll_diff;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pos_q    <= INIT_P[15:0];
         vel_q    <= '0;
         coll_q   <= 1'b0;
         bounce_q <= 1'b0;
         scroll_q <= '0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         vel_q    <= vel_d;
         coll_q   <= coll_d;
         bounce_q <= bounce_d;
         scroll_q <= scroll_d;
      end
   end

   always_comb begin
      // 17-bit sums keep the full range visible to the clamps.
      pos_n = $signed({pos_q[15], pos_q})
            + $signed({{5{vel_q[11]}}, vel_q});
      vel_s = $signed({vel_q[11], vel_q}) + GRAV;
      vel_n = (vel_s > MAXF) ? MAXF[11:0] : vel_s[11:0];
      land_y = (ground_y > H_SPR) ? ground_y - H_SPR : '0;
      active = (state_q == S_RISING) || (state_q == S_FALLING);
`ifdef DOODLE_SCROLL_EN
      pos_int     = pos_n >>> FRAC_BITS;
      scroll_diff = SCROLL_I - pos_int;
`endif

      state_d  = state_q;
      pos_d    = pos_q;
      vel_d    = vel_q;
      bounce_d = 1'b0;
      scroll_d = '0;

      // The landing latch holds until the next tick consumes it.
      coll_d = coll_q;
      if (start || frame_tick)
         coll_d = 1'b0;
      else if (doodle_collision && state_q == S_FALLING)
         coll_d = 1'b1;

      if (start && !active) begin
         state_d = S_FALLING;
         pos_d   = INIT_P[15:0];
         vel_d   = '0;
      end else if (frame_tick && active) begin
         if (state_q == S_FALLING && (coll_q || doodle_collision)) begin
            state_d  = S_RISING;
            pos_d    = 16'({6'b0, land_y} << FRAC_BITS);
            vel_d    = JUMP;
            bounce_d = 1'b1;
         end else if (pos_n >= SCREEN_P) begin
            state_d = S_DEAD;
            pos_d   = DEAD_P[15:0];
            vel_d   = '0;
         end
`ifdef DOODLE_SCROLL_EN
         else if (state_q == S_RISING && pos_int < SCROLL_I) begin
            state_d  = vel_n[11] ? S_RISING : S_FALLING;
            pos_d    = SCROLL_P[15:0];
            vel_d    = vel_n;
            scroll_d = scroll_diff[9:0];
         end
`endif
         else if (pos_n[16]) begin
            state_d = S_FALLING;
            pos_d   = '0;
            vel_d   = '0;
         end else begin
            state_d = vel_n[11] ? S_RISING : S_FALLING;
            pos_d   = pos_n[15:0];
            vel_d   = vel_n;
         end
      end
   end

   always_comb begin
      doodle_fall_direction = (state_q == S_FALLING) && !vel_q[11];
      dead                  = (state_q == S_DEAD);
   end

   assign doodle_y  = pos_q[FRAC_BITS +: 10];
   assign velocity  = vel_q;
   assign bounce    = bounce_q;
   assign scroll_px = scroll_q;

endmodule

// File: tb/tb_doodle_physics.sv
// tb_doodle_physics: self-checking bench for doodle_physics.
// Table-driven vectors go through a scoreboard queue; the long fall uses a kinematics model.
module tb_doodle_physics;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               frame_tick = 1'b0;
   logic               doodle_collision = 1'b0;
   logic [9:0]         ground_y = 10'd767;
   logic [9:0]         doodle_y;
   logic               doodle_fall_direction;
   logic signed [11:0] velocity;
   logic               bounce;
   logic               dead;
   logic [9:0]         scroll_px;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit r, s, t, c;
      int g;
      int y, v;
      bit f, b, d;
      int sc;
   } vec_t;

   vec_t tab[$];
   vec_t exp_q[$];

   doodle_physics dut (
      .clk                   (clk),
      .rst                   (rst),
      .start                 (start),
      .frame_tick            (frame_tick),
      .doodle_collision      (doodle_collision),
      .ground_y              (ground_y),
      .doodle_y              (doodle_y),
      .doodle_fall_direction (doodle_fall_direction),
      .velocity              (velocity),
      .bounce                (bounce),
      .dead                  (dead),
      .scroll_px             (scroll_px)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input bit r, s, t, c, input int g,
                               input int y, v, input bit f, b, d,
                               input int sc);
      vec_t x;
      x.r = r; x.s = s; x.t = t; x.c = c; x.g = g;
      x.y = y; x.v = v; x.f = f; x.b = b; x.d = d; x.sc = sc;
      return x;
   endfunction

   task automatic cmp(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_out();
      vec_t e;
      if (exp_q.size() == 0) begin
         cmp("scoreboard_empty", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      cmp("doodle_y", int'(doodle_y), e.y);
      cmp("velocity", int'(velocity), e.v);
      cmp("fall_dir", int'(doodle_fall_direction), int'(e.f));
      cmp("bounce", int'(bounce), int'(e.b));
      cmp("dead", int'(dead), int'(e.d));
      cmp("scroll_px", int'(scroll_px), e.sc);
   endtask

   task automatic apply(input vec_t v);
      rst = v.r;
      start = v.s;
      frame_tick = v.t;
      doodle_collision = v.c;
      ground_y = 10'(v.g);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      rst = 1'b0;
      start = 1'b0;
      frame_tick = 1'b0;
      doodle_collision = 1'b0;
      check_out();
   endtask

   task automatic run_table();
      for (int i = 0; i < tab.size(); i++)
         apply(tab[i]);
      tab.delete();
   endtask

   // Free fall from (p, v) in Q.4 until the bottom edge kills the doodle.
   task automatic fall_to_dead(input int p0, input int v0);
      int p, v, np;
      bit died;
      p = p0;
      v = v0;
      died = 1'b0;
      for (int k = 0; k < 300 && !died; k++) begin
         np = p + v;
         if (np >= 768 * 16) begin
            apply(mk(0,0,1,0,767, 767,0,0,0,1,0));
            died = 1'b1;
         end else begin
            p = np;
            v = (v + 6 > 256) ? 256 : v + 6;
            apply(mk(0,0,1,0,767, p >> 4,v,1,0,0,0));
         end
      end
      cmp("reached_dead", int'(died), 1);
   endtask

   initial begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      cmp("rst_doodle_y", int'(doodle_y), 687);
      cmp("rst_velocity", int'(velocity), 0);
      cmp("rst_fall", int'(doodle_fall_direction), 0);
      cmp("rst_dead", int'(dead), 0);
      cmp("rst_bounce", int'(bounce), 0);
      cmp("rst_scroll", int'(scroll_px), 0);

      // Idle, start, integration, latched landing, rising.
      tab.push_back(mk(0,0,1,0,767, 687,0,0,0,0,0));
      tab.push_back(mk(0,0,0,1,767, 687,0,0,0,0,0));
      tab.push_back(mk(0,1,0,0,767, 687,0,1,0,0,0));
      tab.push_back(mk(0,0,1,0,767, 687,6,1,0,0,0));
      tab.push_back(mk(0,0,1,0,767, 687,12,1,0,0,0));
      tab.push_back(mk(0,0,0,1,767, 687,12,1,0,0,0));
      tab.push_back(mk(0,0,0,0,767, 687,12,1,0,0,0));
      tab.push_back(mk(0,0,0,0,767, 687,12,1,0,0,0));
      tab.push_back(mk(0,0,1,0,767, 687,-224,0,1,0,0));
      tab.push_back(mk(0,0,0,0,767, 687,-224,0,0,0,0));
      tab.push_back(mk(0,0,1,0,767, 673,-218,0,0,0,0));
      tab.push_back(mk(0,0,1,1,767, 659,-212,0,0,0,0));
      tab.push_back(mk(0,1,0,0,767, 659,-212,0,0,0,0));
      run_table();

      // Asynchronous reset mid-cycle.
      #2;
      rst = 1'b1;
      #1;
      cmp("async_rst_y", int'(doodle_y), 687);
      cmp("async_rst_vel", int'(velocity), 0);
      cmp("async_rst_fall", int'(doodle_fall_direction), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Coincident landing, scroll line, start+tick priority.
      tab.push_back(mk(0,1,0,0,767, 687,0,1,0,0,0));
      tab.push_back(mk(0,0,1,1,505, 425,-224,0,1,0,0));
`ifdef DOODLE_SCROLL_EN
      tab.push_back(mk(0,0,1,0,505, 420,-218,0,0,0,9));
      tab.push_back(mk(0,0,0,0,505, 420,-218,0,0,0,0));
`else
      tab.push_back(mk(0,0,1,0,505, 411,-218,0,0,0,0));
      tab.push_back(mk(0,0,0,0,505, 411,-218,0,0,0,0));
`endif
      tab.push_back(mk(1,0,0,0,767, 687,0,0,0,0,0));
      tab.push_back(mk(0,1,1,0,767, 687,0,1,0,0,0));
      tab.push_back(mk(0,0,1,0,767, 687,6,1,0,0,0));
      run_table();

      fall_to_dead(687 * 16, 6);

      // Dead is frozen; restart; landing on low ground; top clamp.
      tab.push_back(mk(0,0,1,0,767, 767,0,0,0,1,0));
      tab.push_back(mk(0,0,1,1,767, 767,0,0,0,1,0));
      tab.push_back(mk(0,1,0,0,767, 687,0,1,0,0,0));
      tab.push_back(mk(0,0,1,1,50, 0,-224,0,1,0,0));
      tab.push_back(mk(0,0,0,0,50, 0,-224,0,0,0,0));
`ifdef DOODLE_SCROLL_EN
      tab.push_back(mk(0,0,1,0,50, 420,-218,0,0,0,434));
`else
      tab.push_back(mk(0,0,1,0,50, 0,0,1,0,0,0));
`endif
      run_table();

`ifndef DOODLE_SCROLL_EN
      // Full fall from the top reaches terminal velocity before death.
      fall_to_dead(0, 0);
`endif

      cmp("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
